// File: rtl/demo_frm_rx.sv
// demo_frm_rx: hunts SYNC, reads a length byte and packs the payload little-endian into DATA_W words.
// Define DEMO_FRM_RX_CHK_EN to require and verify a trailing XOR checksum byte.
module demo_frm_rx #(
  parameter int DATA_W = 32,
  parameter int MAX_LEN = 64,
  parameter logic [7:0] SYNC = 8'hA5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_vld,
  input  logic [7:0]          in_data,
  output logic                in_rdy,
  output logic                out_vld,
  output logic [DATA_W-1:0]   out_data,
  output logic [DATA_W/8-1:0] out_keep,
  output logic                out_last,
  output logic                out_err,
  input  logic                out_rdy,
  output logic [15:0]         frm_cnt,
  output logic [15:0]         drop_cnt
);
  localparam int NB = DATA_W / 8;
  localparam int LW = $clog2(NB) + 1;
  localparam logic [7:0] MAX_B = 8'(MAX_LEN);
  localparam logic [1:0] HUNT = 2'd0;
  localparam logic [1:0] LEN = 2'd1;
  localparam logic [1:0] PAY = 2'd2;
  logic [1:0] state;
  logic [7:0] rem;
  logic [LW-1:0] lane, fill;
  logic [DATA_W-1:0] pack, pack_n;
  logic [NB-1:0] keep_n;
  logic acc, full, fin;
`ifdef DEMO_FRM_RX_CHK_EN
  localparam logic [1:0] CHK = 2'd3;
  logic [7:0] chk;
  logic err;
  // lane already holds the filled-lane count while waiting for the checksum
  assign fill = lane;
  assign out_err = err;
`else
  assign fill = lane + LW'(1);
  assign out_err = 1'b0;
`endif
  assign in_rdy = !out_vld || out_rdy;
  assign acc = in_vld && in_rdy;
  assign full = lane == LW'(NB - 1);
  assign fin = rem == 8'd1;
  assign pack_n = pack | (DATA_W'(in_data) << {lane, 3'b000});
  assign keep_n = (NB'(1) << fill) - NB'(1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HUNT;
      rem <= '0;
      lane <= '0;
      pack <= '0;
      out_vld <= 1'b0;
      out_data <= '0;
      out_keep <= '0;
      out_last <= 1'b0;
      frm_cnt <= '0;
      drop_cnt <= '0;
`ifdef DEMO_FRM_RX_CHK_EN
      chk <= '0;
      err <= 1'b0;
`endif
    end else begin
      if (out_vld && out_rdy) out_vld <= 1'b0;
      if (out_vld && out_rdy && out_last && !out_err && frm_cnt != 16'hFFFF) frm_cnt <= frm_cnt + 16'd1;
      if (acc) begin
        case (state)
          HUNT: if (in_data == SYNC) state <= LEN;
          LEN: begin
            if (in_data == 8'd0 || in_data > MAX_B) begin
              if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
              state <= HUNT;
            end else begin
              rem <= in_data;
              lane <= '0;
              pack <= '0;
              state <= PAY;
`ifdef DEMO_FRM_RX_CHK_EN
              chk <= in_data;
`endif
            end
          end
          PAY: begin
            rem <= rem - 8'd1;
`ifdef DEMO_FRM_RX_CHK_EN
            chk <= chk ^ in_data;
`endif
            if (fin) begin
`ifdef DEMO_FRM_RX_CHK_EN
              pack <= pack_n;
              lane <= lane + LW'(1);
              state <= CHK;
`else
              out_vld <= 1'b1;
              out_data <= pack_n;
              out_keep <= keep_n;
              out_last <= 1'b1;
              state <= HUNT;
`endif
            end else if (full) begin
              out_vld <= 1'b1;
              out_data <= pack_n;
              out_keep <= '1;
              out_last <= 1'b0;
`ifdef DEMO_FRM_RX_CHK_EN
              err <= 1'b0;
`endif
              pack <= '0;
              lane <= '0;
            end else begin
              pack <= pack_n;
              lane <= lane + LW'(1);
            end
          end
`ifdef DEMO_FRM_RX_CHK_EN
          CHK: begin
            out_vld <= 1'b1;
            out_data <= pack;
            out_keep <= keep_n;
            out_last <= 1'b1;
            err <= in_data != chk;
            if (in_data != chk && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            state <= HUNT;
          end
`endif
          default: state <= HUNT;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_demo_frm_rx.sv
// tb_demo_frm_rx: directed and random frames; expected words are queued per frame and popped on each output handshake.
module tb_demo_frm_rx;
  localparam int DW = 32;
  localparam int NB = DW / 8;
  localparam int MAXL = 64;
`ifdef DEMO_FRM_RX_CHK_EN
  localparam bit CE = 1'b1;
`else
  localparam bit CE = 1'b0;
`endif
  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [DW-1:0] d;
    logic [NB-1:0] k;
    logic l;
    logic e;
  } word_t;
  logic clk = 1'b0, rst = 1'b1, in_vld = 1'b0, out_rdy = 1'b1;
  logic [7:0] in_data = '0;
  logic in_rdy, out_vld, out_last, out_err;
  logic [DW-1:0] out_data;
  logic [NB-1:0] out_keep;
  logic [15:0] frm_cnt, drop_cnt;
  word_t q[$];
  int n_chk = 0, n_pass = 0, exp_frm = 0, exp_drop = 0, rdy_mode = 0;
  bq_t good;

  demo_frm_rx #(.DATA_W(DW), .MAX_LEN(MAXL), .SYNC(8'hA5)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_data(in_data), .in_rdy(in_rdy),
    .out_vld(out_vld), .out_data(out_data), .out_keep(out_keep), .out_last(out_last),
    .out_err(out_err), .out_rdy(out_rdy), .frm_cnt(frm_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  always begin
    @(negedge clk);
    out_rdy = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'b0 : ($urandom_range(0, 9) < 7);
  end

  always begin
    word_t w;
    @(negedge clk);
    #1;
    if (!rst && out_vld && out_rdy) begin
      if (q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_word: got %0h expected none", out_data);
      end else begin
        w = q.pop_front();
        check("word_data", 64'(out_data), 64'(w.d));
        check("word_keep", 64'(out_keep), 64'(w.k));
        check("word_last", 64'(out_last), 64'(w.l));
        check("word_err", 64'(out_err), 64'(w.e));
        if (w.l && !w.e) exp_frm++;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    @(negedge clk);
    in_vld = 1'b1;
    in_data = b;
    #1;
    while (!in_rdy) begin
      t++;
      if (t > 500) begin
        n_chk++;
        $display("FAIL in_rdy_timeout: got 0 expected 1");
        in_vld = 1'b0;
        return;
      end
      @(negedge clk);
      #1;
    end
    @(posedge clk);
    #1 in_vld = 1'b0;
  endtask

  task automatic send_badlen(input logic [7:0] l);
    exp_drop++;
    send_byte(8'hA5);
    send_byte(l);
  endtask

  // flip != 0 corrupts the checksum byte
  task automatic send_frame(input bq_t pl, input logic [7:0] flip);
    int l = pl.size();
    logic [7:0] cs = 8'(l);
    for (int i = 0; i < l; i += NB) begin
      word_t w;
      w.d = '0;
      w.k = '0;
      for (int j = 0; j < NB && i + j < l; j++) begin
        w.d[8*j +: 8] = pl[i+j];
        w.k[j] = 1'b1;
      end
      w.l = i + NB >= l;
      w.e = CE && flip != 0 && w.l;
      q.push_back(w);
    end
    if (CE && flip != 0) exp_drop++;
    send_byte(8'hA5);
    send_byte(8'(l));
    foreach (pl[i]) begin
      send_byte(pl[i]);
      cs ^= pl[i];
    end
    if (CE) send_byte(cs ^ flip);
  endtask

  task automatic drain();
    int t = 0;
    while ((q.size() != 0 || out_vld) && t < 3000) begin
      @(negedge clk);
      #1;
      t++;
    end
    repeat (2) @(negedge clk);
    #1;
    check("queue_drained", 64'(q.size()), 64'd0);
    check("frm_cnt", 64'(frm_cnt), 64'(exp_frm));
    check("drop_cnt", 64'(drop_cnt), 64'(exp_drop));
  endtask

  initial begin
    bq_t pl;
    int t;
    logic [7:0] g;
    logic [DW-1:0] held;
    good = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_vld", 64'(out_vld), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_keep", 64'(out_keep), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_out_err", 64'(out_err), 64'd0);
    check("rst_frm_cnt", 64'(frm_cnt), 64'd0);
    check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_rdy", 64'(in_rdy), 64'd1);
    send_frame(good, 8'h00);
    drain();
`ifdef DEMO_FRM_RX_CHK_EN
    send_frame(good, 8'h01);
    drain();
`endif
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    pl = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_frame(pl, 8'h00);
    drain();
    send_badlen(8'h00);
    send_badlen(8'h41);
    send_frame(good, 8'h00);
    drain();
    rdy_mode = 1;
    fork
      send_frame(good, 8'h00);
    join_none
    t = 0;
    while (!out_vld && t < 200) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("bp_word_pending", 64'(out_vld), 64'd1);
    held = 32'h44332211;
    repeat (10) begin
      @(negedge clk);
      #1;
      check("bp_in_rdy", 64'(in_rdy), 64'd0);
      check("bp_out_data", 64'(out_data), 64'(held));
    end
    rdy_mode = 0;
    wait fork;
    drain();
    send_byte(8'hA5);
    send_byte(8'h05);
    send_byte(8'h11);
    send_byte(8'h22);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_frm = 0;
    exp_drop = 0;
    check("mid_rst_out_vld", 64'(out_vld), 64'd0);
    check("mid_rst_out_data", 64'(out_data), 64'd0);
    check("mid_rst_out_keep", 64'(out_keep), 64'd0);
    check("mid_rst_out_last", 64'(out_last), 64'd0);
    check("mid_rst_out_err", 64'(out_err), 64'd0);
    check("mid_rst_frm_cnt", 64'(frm_cnt), 64'd0);
    check("mid_rst_drop_cnt", 64'(drop_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_in_rdy", 64'(in_rdy), 64'd1);
    send_frame(good, 8'h00);
    drain();
    rdy_mode = 2;
    for (int f = 0; f < 150; f++) begin
      repeat ($urandom_range(0, 3)) begin
        g = 8'($urandom);
        send_byte(g == 8'hA5 ? 8'h00 : g);
      end
      if ($urandom_range(0, 9) == 0) begin
        send_badlen($urandom_range(0, 1) == 0 ? 8'h00 : 8'($urandom_range(MAXL + 1, 255)));
      end else begin
        pl = {};
        t = $urandom_range(0, 3) == 0 ? NB * $urandom_range(1, MAXL / NB) : $urandom_range(1, MAXL);
        repeat (t) pl.push_back(8'($urandom));
        send_frame(pl, $urandom_range(0, 4) == 0 ? 8'($urandom_range(1, 255)) : 8'h00);
      end
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      if (f % 25 == 24) drain();
    end
    rdy_mode = 0;
    drain();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
